// File: rtl/stopwatch_cu_pkg.sv
// Shared definitions for the stopwatch control unit: FSM state encoding and default timing.
package stopwatch_cu_pkg;

  typedef enum logic [1:0] {
    StStop  = 2'b00,
    StRun   = 2'b01,
    StClear = 2'b10
  } state_e;

  // 1 kHz sample strobe from a 100 MHz clock, 8 equal samples to accept a level
  localparam int unsigned SampleDivDefault = 100_000;
  localparam int unsigned DbCountDefault   = 8;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, sampled debounce and
// rising-edge detect producing one clk-wide press pulse.
module btn_debounce
  import stopwatch_cu_pkg::*;
#(
  parameter int unsigned DB_COUNT = DbCountDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_sample,
  output logic o_pulse
);

  logic                sync1_q;
  logic                sync2_q;
  logic [DB_COUNT-1:0] shift_q;
  logic                level_q;
  logic                level_d;
  logic                level_d1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      shift_q    <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      if (i_sample) begin
        shift_q <= {shift_q[DB_COUNT-2:0], sync2_q};
      end
      level_q    <= level_d;
      level_d1_q <= level_q;
    end
  end

  // Level only moves on a unanimous sample window; mixed windows hold it.
  always_comb begin
    level_d = level_q;
    if (&shift_q) begin
      level_d = 1'b1;
    end else if (~|shift_q) begin
      level_d = 1'b0;
    end
  end

  assign o_pulse = level_q & ~level_d1_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounces run/stop and clear buttons and drives the
// datapath's run level and clear pulse from a 3-state Moore FSM.
module stopwatch_cu
  import stopwatch_cu_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SampleDivDefault,
  parameter int unsigned DB_COUNT   = DbCountDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic [1:0] o_state
);

  localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            sample;
  logic            run_pulse;
  logic            clear_pulse;
  state_e          state_q;
  state_e          state_d;

  assign sample = (cnt_q == CntW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (sample) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  btn_debounce #(
    .DB_COUNT (DB_COUNT)
  ) u_db_run (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (i_btn_run),
    .i_sample (sample),
    .o_pulse  (run_pulse)
  );

  btn_debounce #(
    .DB_COUNT (DB_COUNT)
  ) u_db_clear (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (i_btn_clear),
    .i_sample (sample),
    .o_pulse  (clear_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStop;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear has priority when stopped; it is ignored while running.
  always_comb begin
    state_d = StStop;
    case (state_q)
      StStop: begin
        if (clear_pulse) begin
          state_d = StClear;
        end else if (run_pulse) begin
          state_d = StRun;
        end else begin
          state_d = StStop;
        end
      end
      StRun:   state_d = run_pulse ? StStop : StRun;
      StClear: state_d = StStop;
      default: state_d = StStop;
    endcase
  end

  always_comb begin
    o_run_stop = (state_q == StRun);
    o_clear    = (state_q == StClear);
    o_state    = state_q;
  end

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu with a sample-history model of the button chain.
module tb_stopwatch_cu;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run;
  logic       btn_clear;
  logic       run_stop;
  logic       clr;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_cu #(
    .SAMPLE_DIV (SD),
    .DB_COUNT   (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_run   (btn_run),
    .i_btn_clear (btn_clear),
    .o_run_stop  (run_stop),
    .o_clear     (clr),
    .o_state     (state)
  );

  // Model: each button keeps the value and length of its latest run of equal samples.
  logic [1:0] m_s1, m_s2, m_run_val, m_lvl, m_lvl_d, m_state;
  int         m_cnt;
  int         m_run_len [2];

  function automatic logic [1:0] model_next(input logic [1:0] s, input logic run_p,
                                            input logic clr_p);
    if (s == 2'b00) return clr_p ? 2'b10 : (run_p ? 2'b01 : 2'b00);
    if (s == 2'b01) return run_p ? 2'b00 : 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_run_val <= '0; m_lvl <= '0; m_lvl_d <= '0;
      m_state <= '0; m_cnt <= 0;
      m_run_len[0] <= DB; m_run_len[1] <= DB;
    end else begin
      m_s1  <= {btn_clear, btn_run};
      m_s2  <= m_s1;
      m_cnt <= (m_cnt == SD - 1) ? 0 : m_cnt + 1;
      for (int b = 0; b < 2; b++) begin
        if (m_cnt == SD - 1) begin
          if (m_s2[b] == m_run_val[b]) begin
            m_run_len[b] <= (m_run_len[b] >= DB) ? DB : m_run_len[b] + 1;
          end else begin
            m_run_val[b] <= m_s2[b];
            m_run_len[b] <= 1;
          end
        end
        if (m_run_len[b] >= DB) m_lvl[b] <= m_run_val[b];
      end
      m_lvl_d <= m_lvl;
      m_state <= model_next(m_state, m_lvl[0] & ~m_lvl_d[0], m_lvl[1] & ~m_lvl_d[1]);
    end
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_changes = 0;
  int         n_clears  = 0;
  int         n_run_hi  = 0;
  logic [1:0] prev_state = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock: sample at the falling edge and compare against the model every cycle.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      check("rst_state", 32'(state), 32'd0);
      check("rst_run_stop", 32'(run_stop), 32'd0);
      check("rst_clear", 32'(clr), 32'd0);
      prev_state = 2'b00;
    end else begin
      check("model_state", 32'(state), 32'(m_state));
      check("model_run_stop", 32'(run_stop), 32'(m_state == 2'b01));
      check("model_clear", 32'(clr), 32'(m_state == 2'b10));
      check("clear_with_run", 32'(clr & run_stop), 32'd0);
      if (state !== prev_state) n_changes++;
      prev_state = state;
      if (clr) n_clears++;
      if (run_stop) n_run_hi++;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_run(input string name, input int lo, input int hi);
    int lat;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (lat < 0 && run_stop === 1'b1) lat = i;
    end
    check_range(name, lat, lo, hi);
  endtask

  int base_chg, base_clr, base_hi, lat;

  initial begin
    rst = 1'b1; btn_run = 1'b0; btn_clear = 1'b0;
    hold(3);
    rst = 1'b0;
    tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_run_stop", 32'(run_stop), 32'd0);
    check("reset_clear", 32'(clr), 32'd0);

    // Clean press / release / press
    base_chg = n_changes;
    btn_run = 1'b1;
    wait_run("run_latency", 13, 17);
    btn_run = 1'b0; hold(40);
    btn_run = 1'b1; hold(40);
    btn_run = 1'b0; hold(40);
    check("press_twice_changes", 32'(n_changes - base_chg), 32'd2);
    check("press_twice_state", 32'(state), 32'd0);

    // Bounce rejection, settle low then settle high
    base_chg = n_changes;
    for (int i = 0; i < 20; i++) begin btn_run = ~btn_run; hold(3); end
    btn_run = 1'b0; hold(40);
    check("bounce_low_changes", 32'(n_changes - base_chg), 32'd0);
    check("bounce_low_state", 32'(state), 32'd0);
    for (int i = 0; i < 20; i++) begin btn_run = ~btn_run; hold(3); end
    btn_run = 1'b1; hold(40);
    btn_run = 1'b0; hold(40);
    check("bounce_high_changes", 32'(n_changes - base_chg), 32'd1);
    check("bounce_high_state", 32'(state), 32'd1);

    // Clear while running is ignored
    base_clr = n_clears; base_hi = n_run_hi;
    btn_clear = 1'b1; hold(40);
    btn_clear = 1'b0; hold(40);
    check("run_clear_pulses", 32'(n_clears - base_clr), 32'd0);
    check("run_clear_run_hi", 32'(n_run_hi - base_hi), 32'd80);
    check("run_clear_state", 32'(state), 32'd1);
    btn_run = 1'b1; hold(40);
    btn_run = 1'b0; hold(40);
    check("back_to_stop", 32'(state), 32'd0);

    // Clear from stop: single-cycle pulse
    base_clr = n_clears;
    btn_clear = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (clr === 1'b1) lat = i;
    end
    check_range("clear_latency", lat, 13, 17);
    check("clear_state", 32'(state), 32'd2);
    tick();
    check("clear_after_pulse", 32'(clr), 32'd0);
    check("clear_after_state", 32'(state), 32'd0);
    check("clear_after_run", 32'(run_stop), 32'd0);
    hold(30);
    btn_clear = 1'b0; hold(40);
    check("clear_pulse_count", 32'(n_clears - base_clr), 32'd1);

    // Both buttons together: clear wins
    base_clr = n_clears; base_hi = n_run_hi; base_chg = n_changes;
    btn_run = 1'b1; btn_clear = 1'b1; hold(40);
    btn_run = 1'b0; btn_clear = 1'b0; hold(40);
    check("both_clear_count", 32'(n_clears - base_clr), 32'd1);
    check("both_run_hi", 32'(n_run_hi - base_hi), 32'd0);
    check("both_changes", 32'(n_changes - base_chg), 32'd2);
    check("both_state", 32'(state), 32'd0);

    // Asynchronous reset while running with the button still held
    btn_run = 1'b1;
    wait_run("pre_rst_run", 13, 17);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_run_stop", 32'(run_stop), 32'd0);
    check("async_rst_clear", 32'(clr), 32'd0);
    hold(4);
    rst = 1'b0;
    wait_run("held_after_rst", 13, 17);
    btn_run = 1'b0; hold(40);
    check("held_after_rst_state", 32'(state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_cu.md
Name: stopwatch_cu

Overview:
Control unit sitting directly upstream of the stopwatch datapath. Takes two raw push-button inputs (run/stop, clear) and produces the datapath's `run_stop` level and `clear` pulse. Signal path: 2-flop synchronise → debounce → rising-edge detect → 3-state Moore FSM. All outputs are registered; the datapath may OR `o_clear` into its async reset without glitches.

Parameters:
SAMPLE_DIV, 100_000, clk cycles per debounce sample strobe (1 kHz at 100 MHz clk).
DB_COUNT, 8, consecutive equal samples required to change a debounced level (≥2).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
i_btn_run  input  1  raw run/stop button, active-high, asynchronous to clk
i_btn_clear  input  1  raw clear button, active-high, asynchronous to clk
o_run_stop  output  1  1 = datapath counting; level
o_clear  output  1  one-clk-wide clear pulse to datapath
o_state  output  2  current FSM state, for debug/LED display

Behaviour:
- Reset (async, rst=1):
  - FSM goes to STOP; o_run_stop=0, o_clear=0, o_state=STOP.
  - Sync flops, sample counter, sample shift registers, debounced levels and edge-delay flops all go to 0.
- Synchroniser: 2 flops per button; only the second-stage output is used downstream.
- Sample strobe: counter 0..SAMPLE_DIV-1, shared by both buttons; strobe=1 for the single cycle when counter==SAMPLE_DIV-1, then counter wraps to 0.
- Debounce, per button:
  - On each strobe, shift the synced level into a DB_COUNT-bit register.
  - Debounced level is registered: set to 1 when all bits are 1, cleared to 0 when all bits are 0, otherwise held.
  - Bounces shorter than DB_COUNT samples never change the level.
- Edge detect: pulse = debounced & ~debounced_d1, exactly one clk wide. Release (falling edge) generates nothing.
- FSM, Moore; outputs decoded from the state register:
  - STOP: o_run_stop=0, o_clear=0.
    - run pulse → RUN; clear pulse → CLEAR.
    - Both pulses in the same cycle: clear wins → CLEAR.
  - RUN: o_run_stop=1.
    - run pulse → STOP.
    - clear pulse ignored (no clear while running).
    - Both in the same cycle → STOP.
  - CLEAR: o_clear=1, o_run_stop=0.
    - Always → STOP on the next clk; any pulses arriving in this cycle are discarded.
  - Illegal encoding (2'b11) → STOP.
- Latency, from a clean level change on a raw input to the output change:
  - Minimum: 2 + (DB_COUNT-1)·SAMPLE_DIV + 3 clk.
  - Maximum: 2 + DB_COUNT·SAMPLE_DIV + 3 clk.
- Holding a button produces exactly one action; a new action requires release (debounced 0) then a new press.
- rst mid-press: everything returns to reset values. If the button is still held after rst falls, the debounced level rises again after DB_COUNT samples and produces one new pulse. This is intended.
- o_clear is never asserted for more than 1 clk, and never in the same cycle as o_run_stop=1.

Decomposition:
- Shared package: state encoding constants STOP=2'b00, RUN=2'b01, CLEAR=2'b10; default SAMPLE_DIV and DB_COUNT values.
- One sub-module, btn_debounce (inputs clk, rst, i_btn, i_sample; output o_pulse). It contains the synchroniser, sample shift register, debounced level and edge detect.
- stopwatch_cu instantiates btn_debounce twice and owns the sample counter and the FSM.

Test Plan (SAMPLE_DIV=4, DB_COUNT=3):
1. Reset: assert rst mid-sim → o_state=00, o_run_stop=0, o_clear=0 immediately, without waiting for a clk edge; all hold while rst=1.
2. Clean run press: hold i_btn_run 40 clk from STOP → o_run_stop rises once, 13..17 clk after the press edge. Release, press again → o_run_stop falls; exactly 2 state changes in total.
3. Bounce rejection: toggle i_btn_run every 3 clk for 60 clk, then hold 0 → o_state stays STOP and no pulse occurs. Toggling then settling at 1 → exactly one RUN transition.
4. Clear from STOP: press i_btn_clear → o_clear=1 for exactly 1 clk with o_state=10, then o_state=00, o_run_stop=0.
5. Clear while RUN: enter RUN, press i_btn_clear → o_clear stays 0 and o_run_stop stays 1.
6. Simultaneous press in STOP: raise both buttons on the same clk → CLEAR then STOP; o_run_stop never 1.
